// File: rtl/actuated_intersection_ctrl.sv
// Demand-actuated two-approach signal controller with a pedestrian walk phase.
// States: G2/Y2 approach-2 green/yellow | RR_A,RR_B all-red clearance | G1/Y1 approach-1 green/yellow | WALK | PED_CLR walk clearance
module actuated_intersection_ctrl #(
  parameter int MIN_GREEN      = 30,
  parameter int MAX_GREEN      = 120,
  parameter int EXTEND         = 10,
  parameter int YELLOW_CYCLES  = 5,
  parameter int RED_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 20,
  parameter int CW             = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det1,
  input  logic       det2,
  input  logic       ped_btn,
  output logic       red1,
  output logic       yellow1,
  output logic       green1,
  output logic       red2,
  output logic       yellow2,
  output logic       green2,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    G2      = 3'd0,
    Y2      = 3'd1,
    RR_A    = 3'd2,
    G1      = 3'd3,
    Y1      = 3'd4,
    RR_B    = 3'd5,
    WALK    = 3'd6,
    PED_CLR = 3'd7
  } state_t;

  localparam logic [CW-1:0] MIN_T  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_T  = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] EXT_T  = CW'(EXTEND);
  localparam logic [CW-1:0] YEL_T  = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] RR_T   = CW'(RED_RED_CYCLES - 1);
  localparam logic [CW-1:0] WALK_T = CW'(WALK_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic            call1_q, call1_d;
  logic            call2_q, call2_d;
  logic            ped_q, ped_d;
  logic            last1_q, last1_d;

  logic            own_det, conflict, green_done, changed, in_green, enter_green;

  always_comb begin
    own_det    = (state_q == G1) ? det1 : det2;
    conflict   = ((state_q == G1) ? call2_q : call1_q) | ped_q;
    green_done = conflict && (timer_q >= MIN_T) &&
                 (((gap_q == '0) && !own_det) || (timer_q >= MAX_T));

    state_d = state_q;
    case (state_q)
      G2:      if (green_done)       state_d = Y2;
      Y2:      if (timer_q == YEL_T) state_d = RR_A;
      RR_A:    if (timer_q == RR_T)  state_d = ped_q ? WALK : G1;
      G1:      if (green_done)       state_d = Y1;
      Y1:      if (timer_q == YEL_T) state_d = RR_B;
      RR_B:    if (timer_q == RR_T)  state_d = ped_q ? WALK : G2;
      WALK:    if (timer_q == WALK_T) state_d = PED_CLR;
      PED_CLR: if (timer_q == RR_T)  state_d = last1_q ? G2 : G1;
    endcase

    changed     = (state_d != state_q);
    in_green    = (state_q == G1) || (state_q == G2);
    enter_green = changed && ((state_d == G1) || (state_d == G2));

    timer_d = changed ? '0 : ((&timer_q) ? timer_q : timer_q + 1'b1);

    gap_d = gap_q;
    if (enter_green) begin
      gap_d = '0;
    end else if (in_green) begin
      if (own_det)              gap_d = EXT_T;
      else if (gap_q != '0)     gap_d = gap_q - 1'b1;
    end

    // Clearing on green entry takes priority over a detector hit on that same edge.
    call1_d = call1_q;
    if (changed && (state_d == G1))    call1_d = 1'b0;
    else if (det1 && (state_q != G1))  call1_d = 1'b1;

    call2_d = call2_q;
    if (changed && (state_d == G2))    call2_d = 1'b0;
    else if (det2 && (state_q != G2))  call2_d = 1'b1;

    ped_d = ped_q;
    if (changed && (state_d == WALK))      ped_d = 1'b0;
    else if (ped_btn && (state_q != WALK)) ped_d = 1'b1;

    last1_d = last1_q;
    if (state_q == G1)      last1_d = 1'b1;
    else if (state_q == G2) last1_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= G2;
      timer_q <= '0;
      gap_q   <= '0;
      call1_q <= 1'b0;
      call2_q <= 1'b0;
      ped_q   <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      call1_q <= call1_d;
      call2_q <= call2_d;
      ped_q   <= ped_d;
      last1_q <= last1_d;
    end
  end

  always_comb begin
    red1    = 1'b0;
    yellow1 = 1'b0;
    green1  = 1'b0;
    red2    = 1'b0;
    yellow2 = 1'b0;
    green2  = 1'b0;
    walk    = 1'b0;
    case (state_q)
      G2:      begin red1 = 1'b1;   green2 = 1'b1;  end
      Y2:      begin red1 = 1'b1;   yellow2 = 1'b1; end
      G1:      begin green1 = 1'b1; red2 = 1'b1;    end
      Y1:      begin yellow1 = 1'b1; red2 = 1'b1;   end
      WALK:    begin red1 = 1'b1;   red2 = 1'b1;   walk = 1'b1; end
      default: begin red1 = 1'b1;   red2 = 1'b1;    end
    endcase
  end

  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_actuated_intersection_ctrl.sv
// Bench for actuated_intersection_ctrl: directed timing scenarios plus random traffic against a phase model.
module tb_actuated_intersection_ctrl;

  localparam int MIN_G = 30;
  localparam int MAX_G = 60;
  localparam int EXT   = 4;
  localparam int YEL   = 5;
  localparam int RRC   = 2;
  localparam int WLK   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       det1 = 1'b0, det2 = 1'b0, ped_btn = 1'b0;
  logic       red1, yellow1, green1, red2, yellow2, green2, walk, ped_pending;
  logic [2:0] phase;

  actuated_intersection_ctrl #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .EXTEND(EXT), .YELLOW_CYCLES(YEL),
    .RED_RED_CYCLES(RRC), .WALK_CYCLES(WLK), .CW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .det1(det1), .det2(det2), .ped_btn(ped_btn),
    .red1(red1), .yellow1(yellow1), .green1(green1),
    .red2(red2), .yellow2(yellow2), .green2(green2),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // phase model: 0=G2 1=Y2 2=RR_A 3=G1 4=Y1 5=RR_B 6=WALK 7=PED_CLR
  int m_ph, m_t, m_gap;
  bit m_c1, m_c2, m_ped, m_last1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] exp_lamps(input int ph);
    case (ph)
      0:       return 7'b100_001_0;
      1:       return 7'b100_010_0;
      3:       return 7'b001_100_0;
      4:       return 7'b010_100_0;
      6:       return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_gap = 0;
    m_c1 = 0; m_c2 = 0; m_ped = 0; m_last1 = 0;
  endtask

  task automatic model_step(input bit d1, input bit d2, input bit pb);
    int  nx;
    bit  green, own, other;
    nx    = m_ph;
    green = (m_ph == 0) || (m_ph == 3);
    own   = (m_ph == 3) ? d1 : d2;
    other = ((m_ph == 3) ? m_c2 : m_c1) || m_ped;
    if (green && other && m_t >= MIN_G - 1 && ((m_gap == 0 && !own) || m_t >= MAX_G - 1))
      nx = m_ph + 1;
    else if ((m_ph == 1 || m_ph == 4) && m_t == YEL - 1)
      nx = m_ph + 1;
    else if (m_ph == 2 && m_t == RRC - 1)
      nx = m_ped ? 6 : 3;
    else if (m_ph == 5 && m_t == RRC - 1)
      nx = m_ped ? 6 : 0;
    else if (m_ph == 6 && m_t == WLK - 1)
      nx = 7;
    else if (m_ph == 7 && m_t == RRC - 1)
      nx = m_last1 ? 0 : 3;

    if (nx != m_ph && (nx == 0 || nx == 3)) m_gap = 0;
    else if (green) m_gap = own ? EXT : (m_gap > 0 ? m_gap - 1 : 0);

    if (nx == 3 && m_ph != 3)      m_c1 = 0;
    else if (d1 && m_ph != 3)      m_c1 = 1;
    if (nx == 0 && m_ph != 0)      m_c2 = 0;
    else if (d2 && m_ph != 0)      m_c2 = 1;
    if (nx == 6 && m_ph != 6)      m_ped = 0;
    else if (pb && m_ph != 6)      m_ped = 1;

    if (m_ph == 3) m_last1 = 1;
    if (m_ph == 0) m_last1 = 0;

    m_t  = (nx != m_ph) ? 0 : (m_t < 65535 ? m_t + 1 : 65535);
    m_ph = nx;
  endtask

  task automatic check_outputs();
    chk("phase", 32'(phase), 32'(m_ph));
    chk("lamps", 32'({red1, yellow1, green1, red2, yellow2, green2, walk}), 32'(exp_lamps(m_ph)));
    chk("ped_pending", 32'(ped_pending), 32'(m_ped));
    chk("one_head1", int'(red1) + int'(yellow1) + int'(green1), 1);
    chk("one_head2", int'(red2) + int'(yellow2) + int'(green2), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(det1, det2, ped_btn);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    det1 = 0; det2 = 0; ped_btn = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0;
    check_outputs();
  endtask

  initial begin
    int y2_at, g1_at, y1_at, walk_at, walk_n, g2_back, g2_cnt;
    bit seen;

    // idle rest in G2
    do_reset();
    g2_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (red1 && green2 && phase == 3'd0) g2_cnt++;
    end
    chk("s1_rest_g2", g2_cnt, 200);

    // single det1 pulse with quiet approach 2
    do_reset();
    y2_at = -1; g1_at = -1;
    for (int i = 0; i < 60; i++) begin
      det1 = (cyc == 10);
      step();
      if (yellow2 && y2_at < 0) y2_at = cyc;
      if (green1 && g1_at < 0)  g1_at = cyc;
    end
    det1 = 0;
    chk("s2_y2_start", y2_at, MIN_G);
    chk("s2_g1_start", g1_at, MIN_G + YEL + RRC);

    // max-out with det2 held
    do_reset();
    y2_at = -1;
    for (int i = 0; i < 80; i++) begin
      det2 = 1;
      det1 = (cyc == 5);
      step();
      if (yellow2 && y2_at < 0) y2_at = cyc;
    end
    det1 = 0; det2 = 0;
    chk("s3_maxout", y2_at, MAX_G);

    // gap-out after det2 drops, then pedestrian service from G1
    do_reset();
    y2_at = -1; g1_at = -1; y1_at = -1; walk_at = -1; walk_n = 0; g2_back = -1;
    for (int i = 0; i < 120; i++) begin
      det1    = (cyc == 5);
      det2    = (cyc < 40) || (cyc == 55);
      ped_btn = (cyc == 56) || (cyc == 91);
      step();
      if (yellow2 && y2_at < 0) y2_at = cyc;
      if (green1 && g1_at < 0)  g1_at = cyc;
      if (yellow1 && y1_at < 0) y1_at = cyc;
      if (walk) begin
        walk_n++;
        if (walk_at < 0) walk_at = cyc;
        chk("s5_ped_in_walk", 32'(ped_pending), 0);
      end
      if (green2 && walk_at >= 0 && g2_back < 0) g2_back = cyc;
      if (cyc == 57) chk("s5_ped_set", 32'(ped_pending), 1);
      if (cyc == 92) chk("s5_ped_ignored", 32'(ped_pending), 0);
    end
    det1 = 0; det2 = 0; ped_btn = 0;
    chk("s4_gapout", y2_at, 40 + EXT + 1);
    chk("s5_g1_start", g1_at, 40 + EXT + 1 + YEL + RRC);
    chk("s5_y1_start", y1_at, 40 + EXT + 1 + YEL + RRC + MIN_G);
    chk("s5_walk_start", walk_at, 40 + EXT + 1 + YEL + RRC + MIN_G + YEL + RRC);
    chk("s5_walk_len", walk_n, WLK);
    chk("s5_g2_return", g2_back, 40 + EXT + 1 + YEL + RRC + MIN_G + YEL + RRC + WLK + RRC);

    // asynchronous reset in the middle of Y1
    do_reset();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      det1    = (cyc == 10);
      det2    = (cyc == 40);
      ped_btn = (cyc == 45);
      step();
      if (phase == 3'd4) begin
        seen = 1;
        break;
      end
    end
    det1 = 0; det2 = 0; ped_btn = 0;
    chk("s6_reach_y1", 32'(seen), 1);
    step();
    chk("s6_ped_before", 32'(ped_pending), 1);
    #3;
    rst_n = 0;
    #1;
    chk("s6_rst_lamps", 32'({red1, yellow1, green1, red2, yellow2, green2, walk}), 32'(7'b100_001_0));
    chk("s6_rst_ped", 32'(ped_pending), 0);
    chk("s6_rst_phase", 32'(phase), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0;
    check_outputs();
    g2_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (green2) g2_cnt++;
    end
    chk("s6_rest_g2", g2_cnt, 50);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      det1    = ($urandom_range(0, 5) == 0);
      det2    = ($urandom_range(0, 4) == 0);
      ped_btn = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/actuated_intersection_ctrl.md
Name: actuated_intersection_ctrl

Overview:
Demand-actuated phase scheduler for a two-approach intersection with a pedestrian crossing. It sequences the six signal heads (red/yellow/green for approaches 1 and 2) plus a walk lamp. Phases are driven by latched vehicle-detector calls and a pedestrian button. Min/max green, gap extension and a fixed all-red clearance are enforced.

Parameters:
MIN_GREEN, 30, minimum green duration in clk cycles (>=1)
MAX_GREEN, 120, maximum green duration while a conflicting call is waiting (>=MIN_GREEN)
EXTEND, 10, gap-extension reload value in cycles
YELLOW_CYCLES, 5, yellow duration (>=1)
RED_RED_CYCLES, 2, all-red clearance duration (>=1)
WALK_CYCLES, 20, pedestrian walk duration (>=1)
CW, 16, width of the phase timer and gap counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
det1  in  1  approach-1 vehicle detector, level, synchronous to clk
det2  in  1  approach-2 vehicle detector, level
ped_btn  in  1  pedestrian request, level
red1/yellow1/green1  out  1 each  approach-1 heads
red2/yellow2/green2  out  1 each  approach-2 heads
walk  out  1  pedestrian walk lamp
ped_pending  out  1  latched pedestrian request
phase  out  3  current state encoding

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all registers clear immediately on rst_n=0.
- States and phase codes: G2=0, Y2=1, RR_A=2, G1=3, Y1=4, RR_B=5, WALK=6, PED_CLR=7.
- Light outputs are decoded combinationally from the registered state (Moore).
  - G2: red1=1, green2=1.
  - Y2: red1=1, yellow2=1.
  - G1: green1=1, red2=1.
  - Y1: yellow1=1, red2=1.
  - RR_A, RR_B, WALK, PED_CLR: red1=red2=1.
  - walk=1 only in WALK.
  - Exactly one head per approach is lit at all times.
- Reset values:
  - State G2, so red1=1, green2=1, all other lamps 0.
  - timer=0, gap=0, call1=call2=0, ped_pending=0, phase=0.
- timer:
  - Clears on every state change.
  - Otherwise increments, saturating at all-ones.
  - A state is left on the edge where timer==DUR-1, so it lasts exactly DUR cycles.
- Calls:
  - call1 sets on any cycle with det1=1 while not in G1; it clears on the edge entering G1.
  - call2 is the mirror (sets when det2=1 while not in G2, clears on entering G2).
- ped_pending:
  - Sets on any cycle with ped_btn=1.
  - Clears on the edge entering WALK; the clear wins over a simultaneous set.
  - Presses during WALK are ignored.
- gap counter (green states only):
  - Own detector high: gap<=EXTEND; else if gap>0, gap<=gap-1.
  - Loads 0 on green entry.
- Green exit (Gx) requires all of:
  - conflicting demand, i.e. the other approach's call or ped_pending;
  - timer>=MIN_GREEN-1;
  - (gap==0 and own detector low) or timer>=MAX_GREEN-1.
- Without conflicting demand, the controller rests in green indefinitely.
- Green exit targets: G2 goes to Y2, G1 goes to Y1.
- Yellow: Yx lasts YELLOW_CYCLES, then goes to its RR state.
- RR_A and RR_B each last RED_RED_CYCLES.
  - If ped_pending, go to WALK.
  - Else RR_A goes to G1 and RR_B goes to G2.
- WALK lasts WALK_CYCLES, then PED_CLR.
- PED_CLR lasts RED_RED_CYCLES, then goes to the green opposite the last-served approach (tracked by a 1-bit register set in G1/G2).
- Alternation is strict: after clearance, the other approach always receives green, even with no call.
- Mid-operation reset: instant return to G2 lamps; walk and all calls drop asynchronously.

Test Plan:
All scenarios use MIN_GREEN=30, MAX_GREEN=60, EXTEND=4, YELLOW=5, RED_RED=2, WALK=8.
1. Release reset, detectors and button idle for 200 cycles -> red1=1, green2=1, phase=0 throughout.
2. One-cycle det1 pulse at cycle 10 after reset, det2=0 -> green2 for cycles 0-29; yellow2 for 30-34; all-red for 35-36; green1 from cycle 37; call1=0 once green1 is lit.
3. det2 held high, det1 pulsed at cycle 5 -> green2 lasts exactly 60 cycles (max-out), then yellow2.
4. det1 pulsed, det2 high until the edge before cycle 40, then low -> yellow2 rises on the 5th clk edge after det2 falls (EXTEND+1).
5. In G1 with call2 set, pulse ped_btn -> ped_pending=1; then Y1 for 5 cycles, RR_B for 2, WALK with walk=1 for 8 cycles (ped_pending=0 from WALK entry), PED_CLR for 2, then G2. ped_btn pressed during WALK leaves ped_pending=0.
6. Assert rst_n=0 mid-Y1 -> same-cycle red1=1, green2=1, yellow1=0, walk=0, ped_pending=0, phase=0; after release the controller rests in G2.
